// File: rtl/cla_adder_pipe_if.sv
// Operand/result stream bundle for cla_adder_pipe.
// The operand side and the result side each carry their own valid/ready pair.
interface cla_adder_pipe_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/cla_adder_pipe.sv
// Pipelined block-carry-lookahead adder/subtractor. Each stage resolves GPS lookahead groups,
// and the group carry ripples from one stage register to the next under a single global stall.
module cla_adder_pipe #(
    parameter int WIDTH  = 16,
    parameter int BLOCK  = 4,
    parameter int STAGES = 2
) (
    input  logic            clk,
    input  logic            rst,
    cla_adder_pipe_if.slave bus
);
    localparam int NGROUPS = WIDTH / BLOCK;
    localparam int SDIV    = (STAGES < 1) ? 1 : STAGES;
    localparam int GPS     = NGROUPS / SDIV;
    localparam int IW      = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    if ((WIDTH % BLOCK) != 0) begin : g_bad_block
        $error("cla_adder_pipe: WIDTH=%0d is not a multiple of BLOCK=%0d", WIDTH, BLOCK);
    end
    if ((STAGES < 1) || (STAGES > NGROUPS) || ((NGROUPS % SDIV) != 0)) begin : g_bad_stages
        $error("cla_adder_pipe: STAGES=%0d must divide NGROUPS=%0d", STAGES, NGROUPS);
    end

    typedef struct packed {
        logic [BLOCK-1:0] s;
        logic             c_top;
        logic             c_out;
    } grp_t;

    // Full lookahead inside one group: carry into bit i is G[i-1:0] | P[i-1:0] & c0.
    function automatic grp_t add_group(input logic [BLOCK-1:0] ga,
                                       input logic [BLOCK-1:0] gb,
                                       input logic             c0);
        logic [BLOCK-1:0] g;
        logic [BLOCK-1:0] p;
        logic [BLOCK:0]   c;
        logic             term;
        grp_t             r;
        g    = ga & gb;
        p    = ga ^ gb;
        c    = '0;
        c[0] = c0;
        for (int i = 1; i <= BLOCK; i++) begin
            c[i] = c0;
            for (int m = 0; m < i; m++) c[i] = c[i] & p[m];
            for (int j = 0; j < i; j++) begin
                term = g[j];
                for (int m = j + 1; m < i; m++) term = term & p[m];
                c[i] = c[i] | term;
            end
        end
        r.s     = p ^ c[BLOCK-1:0];
        r.c_top = c[BLOCK-1];
        r.c_out = c[BLOCK];
        return r;
    endfunction

    // Index k of these arrays is the input seen by stage k.
    logic [STAGES-1:0][WIDTH-1:0] in_a;
    logic [STAGES-1:0][WIDTH-1:0] in_b;
    logic [STAGES-1:0][WIDTH-1:0] in_sum;
    logic [STAGES-1:0]            in_c;
    logic [STAGES-1:0]            in_v;
    logic                         adv;

    assign adv          = !bus.out_valid || bus.out_ready;
    assign bus.in_ready = adv;

    assign in_a[0]   = bus.a;
    assign in_b[0]   = bus.b ^ {WIDTH{bus.sub}};
    assign in_c[0]   = bus.sub | bus.cin;
    assign in_v[0]   = bus.in_valid;
    assign in_sum[0] = '0;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [WIDTH-1:0] nxt_sum;
        logic             nxt_c;
        logic             nxt_top;
        grp_t             grp;
        logic [IW-1:0]    lo;

        // NOTE: blocking assignments here build the carry chain in loop order; every target
        // gets a default first so no latch is inferred.
        always_comb begin
            nxt_sum = in_sum[k];
            nxt_c   = in_c[k];
            nxt_top = 1'b0;
            grp     = '0;
            lo      = '0;
            for (int g = 0; g < GPS; g++) begin
                lo                   = IW'((k * GPS + g) * BLOCK);
                grp                  = add_group(in_a[k][lo +: BLOCK], in_b[k][lo +: BLOCK], nxt_c);
                nxt_sum[lo +: BLOCK] = grp.s;
                nxt_top              = grp.c_top;
                nxt_c                = grp.c_out;
            end
        end

        if (k < STAGES - 1) begin : g_mid
            logic [WIDTH-1:0] a_q;
            logic [WIDTH-1:0] b_q;
            logic [WIDTH-1:0] sum_q;
            logic             c_q;
            logic             v_q;

            // NOTE: data registers are reset too so no X can ever reach the outputs;
            // after reset they only load on valid beats.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    v_q   <= 1'b0;
                    a_q   <= '0;
                    b_q   <= '0;
                    sum_q <= '0;
                    c_q   <= 1'b0;
                end else if (adv) begin
                    v_q <= in_v[k];
                    if (in_v[k]) begin
                        a_q   <= in_a[k];
                        b_q   <= in_b[k];
                        sum_q <= nxt_sum;
                        c_q   <= nxt_c;
                    end
                end
            end

            assign in_a[k+1]   = a_q;
            assign in_b[k+1]   = b_q;
            assign in_sum[k+1] = sum_q;
            assign in_c[k+1]   = c_q;
            assign in_v[k+1]   = v_q;
        end else begin : g_last
            logic [WIDTH-1:0] sum_q;
            logic             c_q;
            logic             ovf_q;
            logic             v_q;

            // Result fields change only on a valid beat, so a bubble leaves the last value showing.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    v_q   <= 1'b0;
                    sum_q <= '0;
                    c_q   <= 1'b0;
                    ovf_q <= 1'b0;
                end else if (adv) begin
                    v_q <= in_v[k];
                    if (in_v[k]) begin
                        sum_q <= nxt_sum;
                        c_q   <= nxt_c;
                        ovf_q <= nxt_top ^ nxt_c;
                    end
                end
            end

            assign bus.out_valid = v_q;
            assign bus.sum       = sum_q;
            assign bus.cout      = c_q;
            assign bus.ovf       = ovf_q;
        end
    end
endmodule

// File: tb/tb_cla_adder_pipe.sv
// Self-checking bench for cla_adder_pipe: directed corner cases, backpressure, mid-stream reset
// and a randomized stream scored against an arithmetic reference model.
module tb_cla_adder_pipe;
    localparam int WIDTH  = 16;
    localparam int BLOCK  = 4;
    localparam int STAGES = 2;

    typedef struct {
        logic [WIDTH-1:0] sum;
        logic             cout;
        logic             ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cla_adder_pipe_if #(.WIDTH(WIDTH)) bus ();

    cla_adder_pipe #(
        .WIDTH (WIDTH),
        .BLOCK (BLOCK),
        .STAGES(STAGES)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int               total = 0;
    int               bad   = 0;
    int               n_in  = 0;
    int               n_out = 0;
    exp_t             sb[$];
    logic             held = 1'b0;
    logic [WIDTH-1:0] held_sum;
    logic             held_cout;
    logic             held_ovf;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the operands as given.
    function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                   input logic cin, input logic sub);
        longint ua, ub, ur, sa, sbv, sr, maxs, mins;
        exp_t   e;
        ua   = longint'(a);
        ub   = longint'(b);
        sa   = a[WIDTH-1] ? ua - (longint'(1) << WIDTH) : ua;
        sbv  = b[WIDTH-1] ? ub - (longint'(1) << WIDTH) : ub;
        maxs = (longint'(1) << (WIDTH - 1)) - 1;
        mins = -(longint'(1) << (WIDTH - 1));
        if (sub) begin
            ur     = ua - ub;
            e.cout = (ua >= ub);
            sr     = sa - sbv;
        end else begin
            ur     = ua + ub + longint'(cin);
            e.cout = ((ur >> WIDTH) != 0);
            sr     = sa + sbv + longint'(cin);
        end
        e.sum = ur[WIDTH-1:0];
        e.ovf = (sr > maxs) || (sr < mins);
        return e;
    endfunction

    function automatic logic [WIDTH-1:0] pick();
        logic [WIDTH-1:0] v;
        v = WIDTH'($urandom);
        case ($urandom_range(7))
            0: v = '0;
            1: v = '1;
            2: v = {1'b1, {(WIDTH-1){1'b0}}};
            3: v = {1'b0, {(WIDTH-1){1'b1}}};
            default: ;
        endcase
        return v;
    endfunction

    // Called at a negedge with inputs already driven; scores this cycle's transfers, then
    // advances one clock and returns at the following negedge.
    task automatic step();
        exp_t e;
        #1;
        if (held) begin
            check("hold_valid", bus.out_valid, 1'b1);
            check("hold_sum", bus.sum, held_sum);
            check("hold_cout", bus.cout, held_cout);
            check("hold_ovf", bus.ovf, held_ovf);
        end
        if (bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                check("spurious_out_valid", bus.out_valid, 1'b0);
            end else begin
                e = sb.pop_front();
                check("sb_sum", bus.sum, e.sum);
                check("sb_cout", bus.cout, e.cout);
                check("sb_ovf", bus.ovf, e.ovf);
                n_out++;
            end
        end
        if (bus.in_valid && bus.in_ready) begin
            sb.push_back(model(bus.a, bus.b, bus.cin, bus.sub));
            n_in++;
        end
        held      = bus.out_valid && !bus.out_ready;
        held_sum  = bus.sum;
        held_cout = bus.cout;
        held_ovf  = bus.ovf;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send_one(input string tag, input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb,
                            input logic vcin, input logic vsub, input logic [WIDTH-1:0] es,
                            input logic ec, input logic eo);
        bus.in_valid  = 1'b1;
        bus.a         = va;
        bus.b         = vb;
        bus.cin       = vcin;
        bus.sub       = vsub;
        bus.out_ready = 1'b1;
        step();
        bus.in_valid = 1'b0;
        for (int i = 1; i < STAGES; i++) begin
            #1 check({tag, "_early_valid"}, bus.out_valid, 1'b0);
            step();
        end
        #1;
        check({tag, "_valid"}, bus.out_valid, 1'b1);
        check({tag, "_sum"}, bus.sum, es);
        check({tag, "_cout"}, bus.cout, ec);
        check({tag, "_ovf"}, bus.ovf, eo);
        step();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [WIDTH-1:0] bp_a[8];
        logic [WIDTH-1:0] bp_b[8];
        logic             bp_s[8];
        int               idx;
        int               out0;
        int               in0;
        logic             acc;

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.cin       = 1'b0;
        bus.sub       = 1'b0;
        bus.out_ready = 1'b1;

        // Reset defaults
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_sum", bus.sum, '0);
        check("rst_cout", bus.cout, 1'b0);
        check("rst_ovf", bus.ovf, 1'b0);
        check("rst_in_ready", bus.in_ready, 1'b1);
        @(negedge clk);

        // Directed add/sub corners
        send_one("add_wrap", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        send_one("add_ovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        send_one("add_cin", 16'h1234, 16'h1111, 1'b1, 1'b0, 16'h2346, 1'b0, 1'b0);
        send_one("sub_ovf", 16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1);
        send_one("sub_neg", 16'h0003, 16'h0005, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);

        // Backpressure: 8 back-to-back beats, sink stalls in cycles 3..6
        for (int i = 0; i < 8; i++) begin
            bp_a[i] = pick();
            bp_b[i] = pick();
            bp_s[i] = 1'($urandom_range(1));
        end
        idx  = 0;
        out0 = n_out;
        for (int c = 0; c < 40 && (n_out - out0) < 8; c++) begin
            bus.out_ready = !(c >= 3 && c <= 6);
            bus.in_valid  = (idx < 8);
            bus.a         = bp_a[idx % 8];
            bus.b         = bp_b[idx % 8];
            bus.sub       = bp_s[idx % 8];
            bus.cin       = 1'b1;
            #1;
            if (bus.out_valid && !bus.out_ready) check("bp_in_ready_low", bus.in_ready, 1'b0);
            acc = bus.in_valid && bus.in_ready;
            step();
            if (acc) idx++;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        check("bp_results", n_out - out0, 8);
        check("bp_sb_empty", sb.size(), 0);

        // Reset with two beats in flight
        for (int i = 0; i < 2; i++) begin
            bus.in_valid = 1'b1;
            bus.a        = pick();
            bus.b        = pick();
            bus.sub      = 1'b0;
            bus.cin      = 1'b0;
            step();
        end
        bus.in_valid = 1'b0;
        rst          = 1'b1;
        held         = 1'b0;
        sb.delete();
        #1 check("midrst_async_valid", bus.out_valid, 1'b0);
        @(posedge clk);
        #1 check("midrst_edge_valid", bus.out_valid, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1 check("midrst_flushed", bus.out_valid, 1'b0);
            step();
        end
        send_one("post_rst", 16'h00F0, 16'h0F0F, 1'b1, 1'b0, 16'h1000, 1'b0, 1'b0);

        // Random stream with random valid/ready
        in0 = n_in;
        for (int c = 0; c < 60000 && (n_in - in0) < 10000; c++) begin
            bus.in_valid  = ($urandom_range(3) != 0);
            bus.out_ready = ($urandom_range(3) != 0);
            bus.a         = pick();
            bus.b         = pick();
            bus.cin       = 1'($urandom_range(1));
            bus.sub       = 1'($urandom_range(1));
            step();
        end
        check("rand_accepted", n_in - in0, 10000);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int c = 0; c < STAGES + 4; c++) step();
        check("rand_drained", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
